unified_cache_mem_scheduler: RTL and testbench



---
 rtl/unified_cache_mem_scheduler_if.sv | 36 +++
 rtl/unified_cache_mem_scheduler.sv | 84 ++++++++
 tb/tb_unified_cache_mem_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/unified_cache_mem_scheduler_if.sv
// unified_cache_mem_scheduler_if: bank miss/writeback requests and the to-memory packet port
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 32
`endif
interface unified_cache_mem_scheduler_if #(
  parameter int NUM_BANK        = 4,
  parameter int PACKET_WIDTH    = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [NUM_BANK*PACKET_WIDTH-1:0] miss_request_flatted_in;
  logic [NUM_BANK-1:0]              miss_request_valid_flatted_in;
  logic [NUM_BANK-1:0]              miss_request_critical_flatted_in;
  logic [NUM_BANK-1:0]              miss_request_ack_out;
  logic [NUM_BANK*PACKET_WIDTH-1:0] writeback_request_flatted_in;
  logic [NUM_BANK-1:0]              writeback_request_valid_flatted_in;
  logic [NUM_BANK-1:0]              writeback_request_critical_flatted_in;
  logic [NUM_BANK-1:0]              writeback_request_ack_out;
  logic [PACKET_WIDTH-1:0]          request_out;
  logic                             request_valid_out;
  logic                             issue_ack_in;
  logic                             fetch_done_in;
  logic [CW-1:0]                    outstanding_count_out;
  modport master (
    output miss_request_flatted_in, miss_request_valid_flatted_in, miss_request_critical_flatted_in,
    output writeback_request_flatted_in, writeback_request_valid_flatted_in, writeback_request_critical_flatted_in,
    output issue_ack_in, fetch_done_in,
    input  miss_request_ack_out, writeback_request_ack_out, request_out, request_valid_out, outstanding_count_out
  );
  modport slave (
    input  miss_request_flatted_in, miss_request_valid_flatted_in, miss_request_critical_flatted_in,
    input  writeback_request_flatted_in, writeback_request_valid_flatted_in, writeback_request_critical_flatted_in,
    input  issue_ack_in, fetch_done_in,
    output miss_request_ack_out, writeback_request_ack_out, request_out, request_valid_out, outstanding_count_out
  );
endinterface

// File: rtl/unified_cache_mem_scheduler.sv
// unified_cache_mem_scheduler: arbitrates bank misses/writebacks into one registered memory request slot
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 32
`endif
module unified_cache_mem_scheduler #(
  parameter int NUM_BANK        = 4,
  parameter int PACKET_WIDTH    = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_AGE_LIMIT    = 8
) (
  input logic clk_in,
  input logic reset_in,
  unified_cache_mem_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_BANK);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(WB_AGE_LIMIT + 1);
  logic [PACKET_WIDTH-1:0] req_q, req_d;
  logic                    valid_q, valid_d, wb_q, wb_d;
  logic [CW-1:0]           out_q, out_d;
  logic [AW-1:0]           age_q, age_d;
  logic [IW-1:0]           mptr_q, mptr_d, wptr_q, wptr_d, ptr, idx;
  logic [NUM_BANK-1:0]     wv, cw, m, cm, mask, onehot;
  logic [CW:0]             cnt_eff;
  logic                    free, fd, depart, elig, age_max, gnt_wb, gnt;
  assign free    = !valid_q || bus.issue_ack_in;
  assign fd      = bus.fetch_done_in && out_q != '0;
  assign depart  = valid_q && bus.issue_ack_in && !wb_q;
  // A miss sitting in the slot (held or departing) already counts against the in-flight budget
  assign cnt_eff = {1'b0, out_q} + (CW+1)'(valid_q && !wb_q) - (CW+1)'(fd);
  assign elig    = cnt_eff < (CW+1)'(MAX_OUTSTANDING);
  assign age_max = age_q == AW'(WB_AGE_LIMIT);
  assign wv      = bus.writeback_request_valid_flatted_in;
  assign cw      = wv & bus.writeback_request_critical_flatted_in;
  assign m       = bus.miss_request_valid_flatted_in & {NUM_BANK{elig}};
  assign cm      = m & bus.miss_request_critical_flatted_in;
  // Class choice: critical wb, critical miss, aged wb, miss, then wb
  assign gnt_wb  = |cw || (!(|cm) && |wv && (age_max || !(|m)));
  assign mask    = gnt_wb ? (|cw ? cw : wv) : (|cm ? cm : m);
  assign ptr     = gnt_wb ? wptr_q : mptr_q;
  assign gnt     = reset_in && free && |mask;
  assign onehot  = NUM_BANK'(1) << idx;
  // Round-robin pick: descending scan so the bank nearest after ptr wins
  always_comb begin
    idx = '0;
    for (int i = NUM_BANK; i >= 1; i--) if (mask[(int'(ptr) + i) % NUM_BANK]) idx = IW'((int'(ptr) + i) % NUM_BANK);
  end
  // Next-state for slot, pointers, in-flight count and writeback age
  always_comb begin
    valid_d = gnt || (valid_q && !bus.issue_ack_in);
    req_d   = !gnt ? req_q : gnt_wb ? bus.writeback_request_flatted_in[int'(idx)*PACKET_WIDTH +: PACKET_WIDTH]
                                    : bus.miss_request_flatted_in[int'(idx)*PACKET_WIDTH +: PACKET_WIDTH];
    wb_d    = gnt ? gnt_wb : wb_q;
    mptr_d  = (gnt && !gnt_wb) ? idx : mptr_q;
    wptr_d  = (gnt && gnt_wb) ? idx : wptr_q;
    out_d   = out_q + CW'(depart) - CW'(fd);
    age_d   = (!(|wv) || (gnt && gnt_wb)) ? '0 : age_max ? age_q : age_q + 1'b1;
  end
  // State registers with asynchronous active-low clear
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      req_q   <= '0;
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      out_q   <= '0;
      age_q   <= '0;
      mptr_q  <= IW'(NUM_BANK - 1);
      wptr_q  <= IW'(NUM_BANK - 1);
    end else begin
      req_q   <= req_d;
      valid_q <= valid_d;
      wb_q    <= wb_d;
      out_q   <= out_d;
      age_q   <= age_d;
      mptr_q  <= mptr_d;
      wptr_q  <= wptr_d;
    end
  end
  assign bus.miss_request_ack_out      = (gnt && !gnt_wb) ? onehot : '0;
  assign bus.writeback_request_ack_out = (gnt && gnt_wb) ? onehot : '0;
  assign bus.request_out               = req_q;
  assign bus.request_valid_out         = valid_q;
  assign bus.outstanding_count_out     = out_q;
endmodule

// File: tb/tb_unified_cache_mem_scheduler.sv
// tb_unified_cache_mem_scheduler: directed scoreboard bench for the memory request scheduler
module tb_unified_cache_mem_scheduler;
  localparam int N = 4, PW = 32, MAXO = 4, LIM = 8;
  logic clk_in = 1'b0;
  logic reset_in = 1'b0;
  int n_chk = 0, n_err = 0;
  logic [PW-1:0] exp_q[$];
  unified_cache_mem_scheduler_if #(.NUM_BANK(N), .PACKET_WIDTH(PW), .MAX_OUTSTANDING(MAXO)) bus();
  unified_cache_mem_scheduler #(.NUM_BANK(N), .PACKET_WIDTH(PW), .MAX_OUTSTANDING(MAXO), .WB_AGE_LIMIT(LIM)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] mpkt(int b);
    return 32'hA000_0000 + PW'(b);
  endfunction
  function automatic logic [PW-1:0] wpkt(int b);
    return 32'hB000_0000 + PW'(b);
  endfunction
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask
  task automatic drive(logic [N-1:0] mv, logic [N-1:0] mc, logic [N-1:0] wv, logic [N-1:0] wc);
    bus.miss_request_valid_flatted_in = mv;
    bus.miss_request_critical_flatted_in = mc;
    bus.writeback_request_valid_flatted_in = wv;
    bus.writeback_request_critical_flatted_in = wc;
  endtask
  task automatic drain();
    drive('0, '0, '0, '0);
    repeat (2) cyc();
    chk("sb_drained", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    reset_in = 1'b0;
    exp_q.delete();
    cyc();
    reset_in = 1'b1;
  endtask
  // Every packet accepted by memory must be the next one the bench predicted
  always @(negedge clk_in) begin
    if (reset_in && bus.request_valid_out && bus.issue_ack_in) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("pkt", bus.request_out, exp_q.pop_front());
    end
  end
  initial begin
    for (int b = 0; b < N; b++) begin
      bus.miss_request_flatted_in[b*PW +: PW] = mpkt(b);
      bus.writeback_request_flatted_in[b*PW +: PW] = wpkt(b);
    end
    bus.issue_ack_in = 1'b1;
    bus.fetch_done_in = 1'b0;
    drive(4'b1111, '0, 4'b1111, '0);
    #12;
    chk("rst_valid", bus.request_valid_out, 0);
    chk("rst_req", bus.request_out, 0);
    chk("rst_out", bus.outstanding_count_out, 0);
    chk("rst_mack", bus.miss_request_ack_out, 0);
    chk("rst_wack", bus.writeback_request_ack_out, 0);
    drive('0, '0, '0, '0);
    cyc();
    reset_in = 1'b1;
    // Single miss on bank 2
    drive(4'b0100, '0, '0, '0);
    #1;
    chk("t1_mack", bus.miss_request_ack_out, 4'b0100);
    chk("t1_wack", bus.writeback_request_ack_out, 0);
    exp_q.push_back(mpkt(2));
    cyc();
    drive('0, '0, '0, '0);
    #1;
    chk("t1_valid", bus.request_valid_out, 1);
    cyc();
    chk("t1_out1", bus.outstanding_count_out, 1);
    bus.fetch_done_in = 1'b1;
    cyc();
    bus.fetch_done_in = 1'b0;
    chk("t1_out0", bus.outstanding_count_out, 0);
    drain();
    do_reset();
    // Round-robin across all banks with a fetch return every cycle
    bus.fetch_done_in = 1'b1;
    drive(4'b1111, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_mack", bus.miss_request_ack_out, 4'b1 << (i % 4));
      chk("t2_out_le1", bus.outstanding_count_out <= 1, 1);
      exp_q.push_back(mpkt(i % 4));
      cyc();
    end
    drain();
    bus.fetch_done_in = 1'b0;
    do_reset();
    // In-flight limit: four misses then stall until a fetch returns
    drive(4'b1111, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_mack", bus.miss_request_ack_out, i < 4 ? 4'b1 << i : 4'b0);
      if (i < 4) exp_q.push_back(mpkt(i));
      cyc();
    end
    chk("t3_out4", bus.outstanding_count_out, 4);
    bus.fetch_done_in = 1'b1;
    #1;
    chk("t3_mack_free", bus.miss_request_ack_out, 4'b0001);
    exp_q.push_back(mpkt(0));
    cyc();
    bus.fetch_done_in = 1'b0;
    #1;
    chk("t3_mack_stall", bus.miss_request_ack_out, 0);
    cyc();
    chk("t3_out4b", bus.outstanding_count_out, 4);
    drain();
    do_reset();
    // Writeback forced after losing WB_AGE_LIMIT cycles
    bus.fetch_done_in = 1'b1;
    drive(4'b1111, '0, 4'b0010, '0);
    for (int i = 0; i < LIM; i++) begin
      #1;
      chk("t4_mack", bus.miss_request_ack_out, 4'b1 << (i % 4));
      chk("t4_wack0", bus.writeback_request_ack_out, 0);
      exp_q.push_back(mpkt(i % 4));
      cyc();
    end
    #1;
    chk("t4_wack", bus.writeback_request_ack_out, 4'b0010);
    chk("t4_mack_none", bus.miss_request_ack_out, 0);
    exp_q.push_back(wpkt(1));
    cyc();
    #1;
    chk("t4_age_clr", bus.writeback_request_ack_out, 0);
    chk("t4_mack_after", bus.miss_request_ack_out, 4'b0001);
    exp_q.push_back(mpkt(0));
    cyc();
    drain();
    bus.fetch_done_in = 1'b0;
    do_reset();
    // Critical priority between classes
    drive(4'b1000, 4'b1000, 4'b0001, '0);
    #1;
    chk("t5_cmiss", bus.miss_request_ack_out, 4'b1000);
    chk("t5_cmiss_w", bus.writeback_request_ack_out, 0);
    exp_q.push_back(mpkt(3));
    cyc();
    drive(4'b1000, 4'b1000, 4'b0001, 4'b0001);
    #1;
    chk("t5_cwb", bus.writeback_request_ack_out, 4'b0001);
    chk("t5_cwb_m", bus.miss_request_ack_out, 0);
    exp_q.push_back(wpkt(0));
    cyc();
    drive(4'b1000, 4'b1000, '0, '0);
    #1;
    chk("t5_cmiss2", bus.miss_request_ack_out, 4'b1000);
    exp_q.push_back(mpkt(3));
    cyc();
    drain();
    do_reset();
    // Slot held by memory back-pressure, then reset mid-hold
    drive(4'b0010, '0, '0, '0);
    #1;
    chk("t6_mack1", bus.miss_request_ack_out, 4'b0010);
    exp_q.push_back(mpkt(1));
    cyc();
    drive(4'b0100, '0, '0, '0);
    #1;
    chk("t6_mack2", bus.miss_request_ack_out, 4'b0100);
    exp_q.push_back(mpkt(2));
    cyc();
    bus.issue_ack_in = 1'b0;
    drive(4'b1000, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_hold_ack", bus.miss_request_ack_out, 0);
      chk("t6_hold_valid", bus.request_valid_out, 1);
      chk("t6_hold_req", bus.request_out, mpkt(2));
      cyc();
    end
    chk("t6_out1", bus.outstanding_count_out, 1);
    reset_in = 1'b0;
    #1;
    chk("t6_rst_valid", bus.request_valid_out, 0);
    chk("t6_rst_out", bus.outstanding_count_out, 0);
    chk("t6_rst_mack", bus.miss_request_ack_out, 0);
    chk("t6_rst_req", bus.request_out, 0);
    exp_q.delete();
    cyc();
    drive('0, '0, '0, '0);
    bus.issue_ack_in = 1'b1;
    reset_in = 1'b1;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
